serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Bit-serial adder that reuses the team's single-bit full adder cell as its datapath. It sits directly upstream of that cell and drives it one bit per clock from operand shift registers. A carry flip-flop closes the loop between bits. It trades WIDTH cycles of latency for a one-bit adder, and is used where area matters more than throughput.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A, sampled with start
b_in  input  WIDTH  operand B, sampled with start
cin  input  1  carry-in, sampled with start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, result valid
sum_out  output  WIDTH  registered sum, held until next completion
cout  output  1  registered carry-out, held until next completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, sum_out=0, cout=0.
  - Shift registers, carry flip-flop and bit counter are cleared.
  - No done pulse is produced for an aborted operation.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge loads a_sh<=a_in, b_sh<=b_in, carry<=cin, cnt<=0, then state->RUN.
  - start=0: remain in IDLE.
- RUN, every edge:
  - The full adder cell sees a_sh[0], b_sh[0] and carry.
  - The sum bit enters sum_sh at the MSB (right shift); carry<=cell carry.
  - a_sh and b_sh shift right; cnt<=cnt+1.
  - When cnt==WIDTH-1 on this edge: sum_out<={sum bit, sum_sh[WIDTH-1:1]}, cout<=cell carry, state->DONE.
- DONE: done=1 for exactly one cycle; next edge state->IDLE.
- Latency: done is high in the cycle after the WIDTH-th edge following the start-sampling edge. Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy=1 (RUN or DONE): ignored. Operands are not resampled and no queueing occurs.
- Operand inputs are don't-care except in the start-sampling cycle.
- cnt width is $clog2(WIDTH).
- Arithmetic: {cout,sum_out} = a_in + b_in + cin, modulo 2^(WIDTH+1).
- sum_out and cout change only on the edge that enters DONE, or on reset.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - When sub=1, b_sh loads ~b_in and carry loads 1; cin is ignored.
  - Result = a_in - b_in modulo 2^WIDTH; cout=1 means no borrow.
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; adder only.

Decomposition:
- Shared package serial_adder_pkg:
  - state enum type (IDLE, RUN, DONE);
  - localparam helper for counter width.
- One sub-module: the existing single-bit full adder cell, instantiated once as the datapath.
- Shift registers, carry flip-flop, counter and FSM live in serial_adder.

Test Plan:
- WIDTH=8, start with a=8'h5A, b=8'h3C, cin=0 -> sum_out=8'h96, cout=0; done pulses exactly 1 cycle, 8 edges after start sampled; busy high RUN..DONE.
- a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout=1. a=8'hFF, b=8'hFF, cin=1 -> sum_out=8'hFF, cout=1.
- Start a=8'h01, b=8'h02; on the 3rd RUN cycle assert start with a=8'hF0, b=8'h0F -> second request ignored; result 8'h03, cout=0; no extra done.
- Start a=8'h5A, b=8'h3C; drop rst_n asynchronously mid-RUN -> outputs 0 immediately, state IDLE, no done. A new start after release gives a correct result.
- With SERIAL_ADDER_SUB_EN, sub=1, a=8'h10, b=8'h03 -> sum_out=8'h0D, cout=1. sub=1, a=8'h03, b=8'h10 -> sum_out=8'hF3, cout=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and counter-width helper for serial_adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: single-bit full adder cell used as the serial datapath.
module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial add of two WIDTH-bit operands, one bit per clock.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' port for a - b.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [WIDTH-2:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign b_load = sub ? ~b_in : b_in;
    assign c_load = sub ? 1'b1 : cin;
`else
    assign b_load = b_in;
    assign c_load = cin;
`endif

    serial_adder_fa u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .co_o(fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a_in;
                b_d     = b_load;
                carry_d = c_load;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_d     = (WIDTH-1)'({fa_s, s_q} >> 1);
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    sum_d   = {fa_s, s_q};
                    cout_d  = fa_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign sum_out = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table plus corner-case sequences for serial_adder.
module tb_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       s;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = '0, b_in = '0;
    logic       cin = 1'b0;
    logic       sub = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum_out;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] prev_sum = '0;
    logic       prev_cout = 1'b0;

    serial_adder #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .cin    (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .sum_out(sum_out),
        .cout   (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic c, input logic s);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = 8'hxx;
        b_in  = 8'hxx;
        chk("busy_after_start", busy, 1);
        chk("hold_sum", sum_out, prev_sum);
        chk("hold_cout", cout, prev_cout);
    endtask

    task automatic finish_op(input int lat0, input logic [7:0] es, input logic ec, input string name);
        int lat = lat0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 8);
        chk({name, "_sum"}, sum_out, es);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_busy_done"}, busy, 1);
        @(negedge clk);
        chk({name, "_done_1cyc"}, done, 0);
        chk({name, "_idle"}, busy, 0);
        chk({name, "_held"}, {cout, sum_out}, {ec, es});
        prev_sum  = es;
        prev_cout = ec;
    endtask

    task automatic no_done(input int cycles, input string name);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(name, seen, 0);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
`ifdef SERIAL_ADDER_SUB_EN
        vecs.push_back('{8'h10, 8'h03, 1'b0, 1'b1, 8'h0D, 1'b1});
        vecs.push_back('{8'h03, 8'h10, 1'b1, 1'b1, 8'hF3, 1'b0});
        vecs.push_back('{8'h44, 8'h44, 1'b0, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0});
`endif

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum_out, 0);
        chk("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        no_done(3, "idle_no_done");

        foreach (vecs[i]) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s);
            finish_op(0, vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));
        end

        // second start on the 3rd RUN cycle must be ignored
        launch(8'h01, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a_in  = 8'hF0;
        b_in  = 8'h0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op(3, 8'h03, 1'b0, "ignore");
        no_done(12, "ignore_no_extra_done");

        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum_out, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum  = '0;
        prev_cout = 1'b0;
        no_done(12, "abort_no_done");
        launch(8'h5A, 8'h3C, 1'b0, 1'b0);
        finish_op(0, 8'h96, 1'b0, "after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
